// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART RX read-side controller
// Contents: read FSM state enum, stat_o bit indices, irq_en_i bit indices,
//           default character-timeout length.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2
  } rd_state_e;

  // stat_o bit positions
  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_FRAME    = 3;
  localparam int STAT_PARITY   = 4;
  localparam int STAT_TIMEOUT  = 5;
  localparam int STAT_REQ_DROP = 6;
  localparam int STAT_RSVD     = 7;

  // irq_en_i bit positions
  localparam int IRQ_LEVEL   = 0;
  localparam int IRQ_TIMEOUT = 1;
  localparam int IRQ_ERROR   = 2;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - saturating idle counter with sticky character-timeout flag
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   activity_i     push or pop this cycle; restarts the idle count
//   level_zero_i   FIFO occupancy is zero; holds the count at 0
//   clr_i          clears the sticky flag (a same-cycle set wins)
//   timeout_o      sticky timeout flag
module uart_rx_timeout
  import uart_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic activity_i,
  input  logic level_zero_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             set;

  always_comb begin
    cnt_d = cnt_q;
    set   = 1'b0;
    if (activity_i || level_zero_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
      // Set only on the step into CNT_MAX so a clear sticks while the
      // counter sits saturated.
      set   = (cnt_d == CNT_MAX);
    end
    flag_d = set | (flag_q & ~clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - RX read-side controller: read FSM, level tracking, sticky status, interrupt
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   rd_req_i                    bus read pulse of the RX data register
//   rd_data_o/rd_valid_o/rd_err_o  read response (err = read while empty)
//   fifo_rden_o, fifo_rd_data_i pop strobe and one-cycle-latency pop data
//   fifo_full_i, fifo_empty_i   FIFO flags
//   fifo_wr_i, rx_stat_i        monitored push strobe and frame/parity pulses
//   thresh_i, irq_en_i, clr_i   level threshold, source enables, sticky clear
//   level_o, stat_o, irq_o      occupancy, status vector, registered interrupt
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int  FIFO_DEPTH     = 10,
  parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_req_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             rd_err_o,
  output logic             fifo_rden_o,
  input  logic [7:0]       fifo_rd_data_i,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_wr_i,
  input  logic [1:0]       rx_stat_i,
  input  logic [LVL_W-1:0] thresh_i,
  input  logic [2:0]       irq_en_i,
  input  logic             clr_i,
  output logic [LVL_W-1:0] level_o,
  output logic [7:0]       stat_o,
  output logic             irq_o
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  rd_state_e        state_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q, rd_err_q, fifo_rden_q;

  logic [LVL_W-1:0] level_q, level_d;
  logic             ovr_q, ovr_d;
  logic             frm_q, frm_d;
  logic             par_q, par_d;
  logic             drop_q, drop_d;
  logic             irq_q, irq_d;
  logic             timeout;
  logic             inc, dec;

  // Read FSM: outputs are registered on the transition into the state
  // they belong to, so fifo_rden_o is high exactly while in POP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      fifo_rden_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      fifo_rden_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req_i) begin
            if (fifo_empty_i) begin
              rd_valid_q <= 1'b1;
              rd_err_q   <= 1'b1;
              rd_data_q  <= 8'h00;
            end else begin
              fifo_rden_q <= 1'b1;
              state_q     <= POP;
            end
          end
        end
        POP: state_q <= CAPT;
        CAPT: begin
          // FIFO data is valid now, one cycle after the pop strobe.
          rd_data_q  <= fifo_rd_data_i;
          rd_valid_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    inc     = fifo_wr_i & ~fifo_full_i;
    dec     = fifo_rden_q;
    level_d = level_q;
    if (inc && !dec && level_q != LVL_MAX) begin
      level_d = level_q + LVL_W'(1);
    end else if (dec && !inc && level_q != '0) begin
      level_d = level_q - LVL_W'(1);
    end

    // Set terms are OR'd last so they win over a same-cycle clear.
    ovr_d  = (fifo_wr_i & fifo_full_i)      | (ovr_q  & ~clr_i);
    frm_d  = rx_stat_i[0]                   | (frm_q  & ~clr_i);
    par_d  = rx_stat_i[1]                   | (par_q  & ~clr_i);
    drop_d = (rd_req_i & (state_q != IDLE)) | (drop_q & ~clr_i);

    irq_d = (irq_en_i[IRQ_LEVEL]   & (thresh_i != '0) & (level_q >= thresh_i))
          | (irq_en_i[IRQ_TIMEOUT] & timeout)
          | (irq_en_i[IRQ_ERROR]   & (ovr_q | frm_q | par_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
      par_q   <= 1'b0;
      drop_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovr_q   <= ovr_d;
      frm_q   <= frm_d;
      par_q   <= par_d;
      drop_q  <= drop_d;
      irq_q   <= irq_d;
    end
  end

  uart_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .activity_i  (fifo_wr_i | fifo_rden_q),
    .level_zero_i(level_q == '0),
    .clr_i       (clr_i),
    .timeout_o   (timeout)
  );

  always_comb begin
    stat_o                = 8'h00;
    stat_o[STAT_EMPTY]    = fifo_empty_i;
    stat_o[STAT_FULL]     = fifo_full_i;
    stat_o[STAT_OVERRUN]  = ovr_q;
    stat_o[STAT_FRAME]    = frm_q;
    stat_o[STAT_PARITY]   = par_q;
    stat_o[STAT_TIMEOUT]  = timeout;
    stat_o[STAT_REQ_DROP] = drop_q;
    stat_o[STAT_RSVD]     = 1'b0;
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_err_o    = rd_err_q;
  assign fifo_rden_o = fifo_rden_q;
  assign level_o     = level_q;
  assign irq_o       = irq_q;

endmodule
